regfile_sb: RTL and testbench

//  Parametrised multi-read-port register file for the pipelined CPU, with a write-through bypass, a

---
 rtl/regfile_sb.sv | 64 ++++++
 tb/tb_regfile_sb.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: multi-read-port register file with write-through bypass, link write port and busy scoreboard
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int LINK_REG = 31
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     link_en,
  input  logic [DATA_W-1:0]        link_data,
  input  logic                     busy_set,
  input  logic [ADDR_W-1:0]        busy_addr
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LINK_A = ADDR_W'(LINK_REG);
  localparam bit ZR = ZERO_REG != 0;
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic              link_we, main_we;
  // link port wins a same-index collision, so the main write is suppressed there
  always_comb begin
    link_we = link_en && !(ZR && LINK_A == '0);
    main_we = wr_en && !(ZR && wr_addr == '0) && !(link_en && wr_addr == LINK_A);
    regs_d  = regs_q;
    busy_d  = busy_q;
    if (main_we) begin
      regs_d[wr_addr] = wr_data;
      busy_d[wr_addr] = 1'b0;
    end
    if (link_we) begin
      regs_d[LINK_A] = link_data;
      busy_d[LINK_A] = 1'b0;
    end
    if (busy_set && !(ZR && busy_addr == '0)) busy_d[busy_addr] = 1'b1;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              lhit, whit;
    assign ra   = rd_addr[i*ADDR_W +: ADDR_W];
    assign lhit = link_en && ra == LINK_A;
    assign whit = wr_en && ra == wr_addr;
    assign rd_data[i*DATA_W +: DATA_W] = (ZR && ra == '0) ? '0 : lhit ? link_data : whit ? wr_data : regs_q[ra];
    // a result arriving this cycle is bypassed, so it no longer stalls the reader
    assign rd_busy[i] = busy_q[ra] & ~(lhit | whit);
  end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: scoreboard bench for regfile_sb; directed tests on the default build, model check on a 3-port build
module tb_regfile_sb;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [9:0]  a_rd_addr = '0;
  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_busy;
  logic        a_wr_en = 1'b0, a_link_en = 1'b0, a_busy_set = 1'b0;
  logic [4:0]  a_wr_addr = '0, a_busy_addr = '0;
  logic [31:0] a_wr_data = '0, a_link_data = '0;

  logic [11:0] b_rd_addr = '0;
  logic [47:0] b_rd_data;
  logic [2:0]  b_rd_busy;
  logic        b_wr_en = 1'b0, b_link_en = 1'b0, b_busy_set = 1'b0;
  logic [3:0]  b_wr_addr = '0, b_busy_addr = '0;
  logic [15:0] b_wr_data = '0, b_link_data = '0;

  regfile_sb dut_a (
    .clk(clk), .reset(reset), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data), .link_en(a_link_en),
    .link_data(a_link_data), .busy_set(a_busy_set), .busy_addr(a_busy_addr)
  );

  regfile_sb #(.DATA_W(16), .ADDR_W(4), .NUM_RD(3), .ZERO_REG(1), .LINK_REG(15)) dut_b (
    .clk(clk), .reset(reset), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .link_en(b_link_en),
    .link_data(b_link_data), .busy_set(b_busy_set), .busy_addr(b_busy_addr)
  );

  string       q_nm[$];
  bit          q_dut[$];
  int          q_p[$];
  logic [31:0] q_d[$];
  logic        q_b[$];
  int          n_chk = 0;
  int          n_fail = 0;
  event        chk_ev;

  task automatic push(input string nm, input bit d_sel, input int p, input logic [31:0] d, input logic b);
    q_nm.push_back(nm);
    q_dut.push_back(d_sel);
    q_p.push_back(p);
    q_d.push_back(d);
    q_b.push_back(b);
  endtask

  task automatic drv_a(input logic we, input logic [4:0] wa, input logic [31:0] wd, input logic le,
                       input logic [31:0] ld, input logic bs, input logic [4:0] ba,
                       input logic [4:0] r0, input logic [4:0] r1);
    a_wr_en = we; a_wr_addr = wa; a_wr_data = wd;
    a_link_en = le; a_link_data = ld;
    a_busy_set = bs; a_busy_addr = ba;
    a_rd_addr = {r1, r0};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // monitor: compares every queued expectation when the outputs are sampled
  initial begin
    string nm;
    bit d_sel;
    int p;
    logic [31:0] ed, ad;
    logic eb, ab;
    forever begin
      @(negedge clk or chk_ev);
      while (q_d.size() > 0) begin
        nm = q_nm.pop_front();
        d_sel = q_dut.pop_front();
        p = q_p.pop_front();
        ed = q_d.pop_front();
        eb = q_b.pop_front();
        ad = d_sel ? {16'h0, b_rd_data[p*16 +: 16]} : a_rd_data[p*32 +: 32];
        ab = d_sel ? b_rd_busy[p] : a_rd_busy[p];
        n_chk++;
        if (ad !== ed) begin
          n_fail++;
          $display("FAIL %s data port%0d: got %h expected %h", nm, p, ad, ed);
        end
        n_chk++;
        if (ab !== eb) begin
          n_fail++;
          $display("FAIL %s busy port%0d: got %b expected %b", nm, p, ab, eb);
        end
      end
    end
  end

  initial begin
    logic [15:0] m [16];
    logic [15:0] mb;
    logic [3:0]  ra;
    logic [15:0] ed;
    logic        eb, lh, wh;
    repeat (2) tick();
    drv_a(0, 0, 0, 0, 0, 0, 0, 5, 0);
    push("reset_state", 0, 0, 0, 0);
    push("reset_state", 0, 1, 0, 0);
    tick();
    // T1: write, claim, then reset mid-operation
    reset = 1'b0;
    drv_a(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 5, 0);
    push("t1_bypass", 0, 0, 32'hDEADBEEF, 0);
    push("t1_r0", 0, 1, 0, 0);
    tick();
    drv_a(0, 0, 0, 0, 0, 1, 5, 5, 0);
    push("t1_held", 0, 0, 32'hDEADBEEF, 0);
    tick();
    drv_a(0, 0, 0, 0, 0, 0, 0, 5, 0);
    push("t1_busy", 0, 0, 32'hDEADBEEF, 1);
    @(negedge clk);
    #2;
    reset = 1'b1;
    drv_a(1, 7, 32'h1234, 0, 0, 1, 7, 5, 7);
    #1;
    push("t1_async", 0, 0, 0, 0);
    push("t1_rst_bypass", 0, 1, 32'h1234, 0);
    ->chk_ev;
    tick();
    drv_a(0, 0, 0, 0, 0, 0, 0, 5, 7);
    push("t1_in_reset", 0, 0, 0, 0);
    push("t1_wr_ignored", 0, 1, 0, 0);
    tick();
    // T2: write-through bypass
    reset = 1'b0;
    drv_a(1, 7, 32'h1234, 0, 0, 0, 0, 7, 5);
    push("t2_bypass", 0, 0, 32'h1234, 0);
    push("t2_lost", 0, 1, 0, 0);
    tick();
    drv_a(0, 0, 0, 0, 0, 1, 31, 7, 31);
    push("t2_stored", 0, 0, 32'h1234, 0);
    push("t2_r31", 0, 1, 0, 0);
    tick();
    // T3: link/main collision on r31, which is also busy
    drv_a(1, 31, 32'h99, 1, 32'h400, 0, 0, 31, 31);
    push("t3_same", 0, 0, 32'h400, 0);
    push("t3_same", 0, 1, 32'h400, 0);
    tick();
    drv_a(0, 0, 0, 0, 0, 0, 0, 31, 31);
    push("t3_after", 0, 0, 32'h400, 0);
    push("t3_after", 0, 1, 32'h400, 0);
    tick();
    // T4: zero register
    drv_a(1, 0, 32'hFFFF, 0, 0, 1, 0, 0, 0);
    push("t4_same", 0, 0, 0, 0);
    push("t4_same", 0, 1, 0, 0);
    tick();
    drv_a(0, 0, 0, 0, 0, 0, 0, 0, 7);
    push("t4_after", 0, 0, 0, 0);
    push("t4_r7", 0, 1, 32'h1234, 0);
    tick();
    // T5: scoreboard
    drv_a(0, 0, 0, 0, 0, 1, 9, 9, 9);
    push("t5_set_same", 0, 0, 0, 0);
    push("t5_set_same", 0, 1, 0, 0);
    tick();
    drv_a(0, 0, 0, 0, 0, 0, 0, 9, 9);
    push("t5_busy", 0, 0, 0, 1);
    push("t5_busy", 0, 1, 0, 1);
    tick();
    drv_a(1, 9, 32'h55, 0, 0, 0, 0, 9, 7);
    push("t5_arrive", 0, 0, 32'h55, 0);
    push("t5_other", 0, 1, 32'h1234, 0);
    tick();
    drv_a(0, 0, 0, 0, 0, 0, 0, 9, 9);
    push("t5_cleared", 0, 0, 32'h55, 0);
    push("t5_cleared", 0, 1, 32'h55, 0);
    tick();
    drv_a(1, 9, 32'h66, 0, 0, 1, 9, 9, 9);
    push("t5_set_wr", 0, 0, 32'h66, 0);
    push("t5_set_wr", 0, 1, 32'h66, 0);
    tick();
    drv_a(0, 0, 0, 0, 0, 0, 0, 9, 9);
    push("t5_set_wins", 0, 0, 32'h66, 1);
    push("t5_set_wins", 0, 1, 32'h66, 1);
    tick();
    drv_a(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // T6: three ports against a model
    for (int k = 0; k < 16; k++) m[k] = '0;
    mb = '0;
    for (int c = 0; c < 2000; c++) begin
      b_wr_en = 1'($urandom_range(0, 1));
      b_wr_addr = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
      b_wr_data = 16'($urandom);
      b_link_en = ($urandom_range(0, 3) == 0);
      b_link_data = 16'($urandom);
      b_busy_set = ($urandom_range(0, 2) == 0);
      b_busy_addr = 4'($urandom);
      for (int p = 0; p < 3; p++) begin
        ra = 4'($urandom);
        if ($urandom_range(0, 3) == 0) ra = b_wr_addr;
        if (p > 0 && $urandom_range(0, 3) == 0) ra = b_rd_addr[(p-1)*4 +: 4];
        b_rd_addr[p*4 +: 4] = ra;
        lh = b_link_en && ra == 4'd15;
        wh = b_wr_en && ra == b_wr_addr;
        ed = (ra == 0) ? 16'h0 : lh ? b_link_data : wh ? b_wr_data : m[ra];
        eb = (ra != 0) && mb[ra] && !lh && !wh;
        push("t6_model", 1, p, {16'h0, ed}, eb);
      end
      if (b_wr_en && b_wr_addr != 0) begin
        if (!(b_link_en && b_wr_addr == 4'd15)) m[b_wr_addr] = b_wr_data;
        mb[b_wr_addr] = 1'b0;
      end
      if (b_link_en) begin
        m[15] = b_link_data;
        mb[15] = 1'b0;
      end
      if (b_busy_set && b_busy_addr != 0) mb[b_busy_addr] = 1'b1;
      tick();
    end
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
